// File: rtl/demux_rr_lanes_if.sv
// demux_rr_lanes_if: input beat stream and per-lane output handshakes of the round-robin demux
// in_data/in_valid/in_ready : single input stream, in_ready is the current target lane's readiness
// out_data/out_valid/out_ready : LANES lane outputs, lane i at out_data[i*DATA_W +: DATA_W]
interface demux_rr_lanes_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2
);
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_valid;
  logic [LANES-1:0]        out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/demux_rr_lanes.sv
// demux_rr_lanes: round-robin spread of one valid-qualified stream over LANES registered output lanes
// clk, reset (async, active-high) ; bus: input stream + lane handshakes (demux_rr_lanes_if.slave)
// resync: realign selector to lane 0 ; lane_sel: current target lane
// drop_cnt: saturating count of beats lost in free-running mode ; overflow: sticky drop flag
module demux_rr_lanes #(
  parameter int DATA_W       = 8,
  parameter int LANES        = 2,
  parameter int SEL_W        = $clog2(LANES),
  parameter int ADV_ON_VALID = 1,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  demux_rr_lanes_if.slave   bus,
  input  logic              resync,
  output logic [SEL_W-1:0]  lane_sel,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow
);
  logic [LANES*DATA_W-1:0] data_q;
  logic [LANES-1:0]        valid_q;
  logic                    accept, drop, adv;
  logic [SEL_W-1:0]        sel_next;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.in_ready  = !valid_q[lane_sel] | bus.out_ready[lane_sel];
  assign accept   = bus.in_valid & bus.in_ready;
  // beats can only be lost when the selector free-runs past a full lane
  assign drop     = bus.in_valid & !bus.in_ready & (ADV_ON_VALID == 0);
  assign adv      = (ADV_ON_VALID == 0) | accept;
  // explicit wrap keeps non-power-of-two lane counts in range
  assign sel_next = (lane_sel == SEL_W'(LANES - 1)) ? '0 : lane_sel + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (accept && lane_sel == SEL_W'(i)) begin
          data_q[i*DATA_W +: DATA_W] <= bus.in_data;
          valid_q[i]                 <= 1'b1;
        end else if (valid_q[i] && bus.out_ready[i]) begin
          data_q[i*DATA_W +: DATA_W] <= '0;
          valid_q[i]                 <= 1'b0;
        end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lane_sel <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      lane_sel <= resync ? '0 : adv ? sel_next : lane_sel;
      if (drop) begin
        drop_cnt <= (&drop_cnt) ? drop_cnt : drop_cnt + 1'b1;
        overflow <= 1'b1;
      end
    end
endmodule

// File: doc/demux_rr_lanes.md
Name: demux_rr_lanes

Overview:
- Parametrised successor to the phy_rx 1x2 byte demux: spreads a single valid-qualified input stream round-robin across LANES output lanes, each DATA_W wide.
- Each lane has a one-entry output register with a valid/ready handshake.
- Two selector modes: legacy free-running alternation, or advance-on-accepted-beat.
- Sits in phy_rx between the deserialiser/byte aligner and the per-lane FIFOs; also adds resynchronisation and drop accounting.

Parameters:
DATA_W, 8, width of input beat and of each lane
LANES, 2, number of output lanes, >=2, need not be a power of two
SEL_W, $clog2(LANES), selector width (derived, do not override)
ADV_ON_VALID, 1, 1 = selector advances only on an accepted beat; 0 = selector advances every cycle (legacy alternating behaviour)
CNT_W, 8, width of drop counter

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_data  input  DATA_W  input beat
in_valid  input  1  in_data qualifier
in_ready  output  1  combinational; current target lane can take a beat
resync  input  1  synchronous; realign selector to lane 0
out_data  output  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
out_valid  output  LANES  per-lane valid
out_ready  input  LANES  per-lane consumer ready
lane_sel  output  SEL_W  current selector value
drop_cnt  output  CNT_W  beats lost (mode 0 only), saturating
overflow  output  1  sticky, set on first dropped beat

Behaviour:
- Reset state (asynchronous, while reset=1): out_data all 0, out_valid all 0, lane_sel 0, drop_cnt 0, overflow 0. Operation resumes on the first rising edge after reset deasserts.
- in_ready = !out_valid[lane_sel] | out_ready[lane_sel]. Combinational, no dependency on in_valid.
- Accept condition: in_valid & in_ready.
  - Lane lane_sel loads in_data, and its out_valid is set on the next edge.
  - Latency from input to lane output is 1 cycle.
- Lane i, no load this cycle:
  - out_valid[i] & out_ready[i]: out_valid[i] <= 0 and out_data[i] <= 0 (lanes read 0 when idle).
  - out_valid[i] & !out_ready[i]: data and valid held.
- Same-cycle drain and load on a lane: the new beat wins, out_valid stays 1, no bubble.
- Selector, ADV_ON_VALID=1:
  - lane_sel <= (lane_sel==LANES-1) ? 0 : lane_sel+1 on each accepted beat.
  - Otherwise held; no beat is ever lost.
- Selector, ADV_ON_VALID=0:
  - lane_sel advances with the same wrap every cycle, regardless of valid.
  - in_valid & !in_ready means the beat is dropped: drop_cnt increments (saturates at 2^CNT_W-1) and overflow <= 1.
  - In mode 1, drop_cnt and overflow stay 0.
- resync=1:
  - lane_sel <= 0 on the next edge, overriding any advance.
  - A beat presented in the same cycle is still accepted or dropped using the current lane_sel.
  - Lane registers are unaffected.
- Wrap for non-power-of-two LANES: lane_sel never exceeds LANES-1 (LANES=3 sequence is 0,1,2,0).
- Reset mid-operation discards pending lane data immediately; no partial beat is retained.
- No X on any output after reset. Lanes are independent: backpressure on lane j never affects lane k except through selector stall in mode 1.

Test Plan:
- LANES=4, ADV_ON_VALID=1, all out_ready=1, in_valid=1 with bytes 0xA0..0xA7 -> lanes 0,1,2,3,0,1,2,3 receive A0,A1,A2,A3,A4,A5,A6,A7, each one cycle after the input; in_ready stays 1; drop_cnt=0.
- Same config, out_ready[1]=0 while lane 1 is full:
  - Expected: in_ready=0 when lane_sel=1; stream stalls and lane_sel holds at 1.
  - Release out_ready[1] -> next beat lands in lane 1 in the same cycle lane 1 drains; no beat lost, order preserved.
- LANES=2, ADV_ON_VALID=0, in_valid pulsed only on odd cycles -> all beats land in lane 1; idle lane 0 reads 0x00 (legacy alternation).
- Mode 0, out_ready[0]=0 held, 6 beats offered -> beats targeting full lane 0 are dropped; drop_cnt=2, overflow=1; beats to lane 1 are delivered.
- LANES=3, resync asserted when lane_sel=2 together with in_valid=1, data 0x55 -> 0x55 lands in lane 2; lane_sel=0 next cycle; with CNT_W=2, 5 drops -> drop_cnt saturates at 3.
- Assert reset asynchronously mid-stream (between edges) -> outputs clear immediately to the reset values; the first beat after deassert goes to lane 0.
